// File: rtl/if_fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage.
// FSM state encodings and PC increment.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction memory request/response bus.
// master = fetch stage, slave = memory.
interface if_fetch_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_skid_buffer.sv
// One-entry {pc, instr} holding register used when a
// response arrives while ID is frozen on a valid entry.
module if_skid_buffer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    // Clear beats load, load beats drain.
    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID register: owns the
// PC, one outstanding imem request, freeze and redirect.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  logic [ADDR_W-1:0]    branch_addr,
    if_fetch_stage_if.master     imem,
    output logic [ADDR_W-1:0]    if_pc,
    output logic [DATA_W-1:0]    if_instr,
    output logic                 if_valid
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic              if_valid_q, if_valid_d;
    logic              stale_q, stale_d;

    logic              hs;
    logic              skid_load, skid_drain, skid_clear;
    logic              skid_full;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_instr;

    assign imem.imem_req  = (state_q == S_REQ) && !rst;
    assign imem.imem_addr = pc_q;
    assign hs = imem.imem_req && imem.imem_ready;

    if_skid_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .pc_i    (req_addr_q + INC),
        .instr_i (imem.imem_rdata),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    // Next state, PC and IF/ID; redirect overrides all.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        stale_d    = stale_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = freeze ? if_valid_q : 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (hs) begin
                    pc_d       = pc_q + INC;
                    req_addr_d = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    state_d = S_REQ;
                    if (stale_q) begin
                        stale_d = 1'b0;
                    end else if (!if_valid_q || !freeze) begin
                        if_instr_d = imem.imem_rdata;
                        if_pc_d    = req_addr_q + INC;
                        if_valid_d = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (!freeze) begin
                    if_pc_d    = skid_pc;
                    if_instr_d = skid_instr;
                    if_valid_d = skid_full;
                    skid_drain = 1'b1;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (branch_taken) begin
            pc_d       = branch_addr;
            if_valid_d = 1'b0;
            if_pc_d    = if_pc_q;
            if_instr_d = if_instr_q;
            skid_load  = 1'b0;
            skid_clear = 1'b1;
            state_d    = S_REQ;
            if ((state_q == S_WAIT && !imem.imem_rvalid) ||
                (state_q == S_REQ && hs)) begin
                stale_d = 1'b1;
                state_d = S_WAIT;
            end
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            stale_q    <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            stale_q    <= stale_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
    assign if_valid = if_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: transaction-level model
// checked every cycle plus directed literal checks.
module tb_if_fetch_stage;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    logic [31:0] poison_addr = 32'h1;

    if_fetch_stage_if #(.ADDR_W(AW), .DATA_W(DW)) imem_bus ();

    if_fetch_stage #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (RPC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem_bus),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_valid     (if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input string nm, input int max);
        int i = 0;
        while (!imem_bus.imem_req && i < max) begin
            step(1);
            i++;
        end
        chk(nm, {31'd0, imem_bus.imem_req}, 32'd1);
    endtask

    task automatic wait_valid(input string nm, input int max);
        int i = 0;
        while (!if_valid && i < max) begin
            step(1);
            i++;
        end
        chk(nm, {31'd0, if_valid}, 32'd1);
    endtask

    // Memory: accepts on req&&ready, answers lat cycles later.
    initial begin : mem
        logic        acc, rs, pend;
        logic [31:0] a, pa;
        int          cnt;
        pend = 1'b0;
        pa = '0;
        cnt = 0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            acc = imem_bus.imem_req && imem_bus.imem_ready;
            a = imem_bus.imem_addr;
            rs = rst;
            @(posedge clk);
            #1;
            imem_bus.imem_rvalid = 1'b0;
            if (rs) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend = 1'b1;
                    pa = a;
                    cnt = lat;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        imem_bus.imem_rvalid = 1'b1;
                        imem_bus.imem_rdata =
                            (pa == poison_addr) ? 32'hDEAD_BEEF : mem_f(pa);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Model: expected fetch PC, outstanding request, queue of
    // responses owed to ID; compared every cycle.
    initial begin : cmp
        logic [63:0] q[$];
        logic [63:0] e;
        logic [31:0] m_pc, m_oaddr, p_pc, p_instr;
        logic        m_out, m_stale, exp_v, exp_r;
        logic        p_rst, p_br, p_frz, p_val;
        m_pc = RPC;
        m_oaddr = '0;
        m_out = 1'b0;
        m_stale = 1'b0;
        p_rst = 1'b1;
        p_br = 1'b0;
        p_frz = 1'b0;
        p_val = 1'b0;
        p_pc = '0;
        p_instr = '0;
        forever begin
            @(negedge clk);
            if (p_rst) begin
                chk("rst_valid", {31'd0, if_valid}, 32'd0);
                chk("rst_pc", if_pc, 32'd0);
                chk("rst_instr", if_instr, 32'd0);
            end else if (p_br) begin
                chk("br_bubble", {31'd0, if_valid}, 32'd0);
            end else if (p_frz && p_val) begin
                chk("hold_valid", {31'd0, if_valid}, 32'd1);
                chk("hold_pc", if_pc, p_pc);
                chk("hold_instr", if_instr, p_instr);
            end else begin
                exp_v = (q.size() > 0);
                chk("valid", {31'd0, if_valid}, {31'd0, exp_v});
                if (if_valid && exp_v) begin
                    e = q.pop_front();
                    chk("if_pc", if_pc, e[63:32]);
                    chk("if_instr", if_instr, e[31:0]);
                end
            end
            exp_r = !rst && !m_out && (q.size() == 0);
            chk("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, exp_r});
            if (imem_bus.imem_req && exp_r)
                chk("imem_addr", imem_bus.imem_addr, m_pc);
            if (rst) begin
                m_pc = RPC;
                m_out = 1'b0;
                m_stale = 1'b0;
                q.delete();
            end else begin
                if (imem_bus.imem_rvalid) begin
                    if (m_out && !m_stale && !branch_taken)
                        q.push_back({m_oaddr + 32'd4, imem_bus.imem_rdata});
                    m_out = 1'b0;
                    m_stale = 1'b0;
                end
                if (imem_bus.imem_req && imem_bus.imem_ready) begin
                    m_out = 1'b1;
                    m_oaddr = m_pc;
                    m_stale = 1'b0;
                    m_pc = m_pc + 32'd4;
                end
                if (branch_taken) begin
                    m_pc = branch_addr;
                    q.delete();
                    if (m_out) m_stale = 1'b1;
                end
            end
            p_rst = rst;
            p_br = branch_taken;
            p_frz = freeze;
            p_val = if_valid;
            p_pc = if_pc;
            p_instr = if_instr;
        end
    end

    // Directed scenarios.
    initial begin : stim
        logic [31:0] a;
        imem_bus.imem_ready = 1'b1;
        step(2);
        rst = 1'b0;
        chk("t1_addr0", imem_bus.imem_addr, 32'h100);
        wait_valid("t1_v0", 10);
        chk("t1_pc0", if_pc, 32'h104);
        chk("t1_in0", if_instr, 32'hC0DE_0100);
        step(1);
        chk("t1_bubble", {31'd0, if_valid}, 32'd0);
        wait_valid("t1_v1", 10);
        chk("t1_pc1", if_pc, 32'h108);
        chk("t1_in1", if_instr, 32'hC0DE_0104);
        step(1);
        wait_valid("t1_v2", 10);
        chk("t1_pc2", if_pc, 32'h10C);

        chk("t4_addr", imem_bus.imem_addr, 32'h10C);
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        step(1);
        branch_taken = 1'b0;
        chk("t4_bub", {31'd0, if_valid}, 32'd0);
        wait_req("t4_req", 10);
        chk("t4_next", imem_bus.imem_addr, 32'h200);

        lat = 3;
        poison_addr = 32'h200;
        step(1);
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        step(1);
        branch_taken = 1'b0;
        chk("t3_bub", {31'd0, if_valid}, 32'd0);
        wait_req("t3_req", 10);
        chk("t3_next", imem_bus.imem_addr, 32'h200);
        poison_addr = 32'h1;
        lat = 1;
        wait_valid("t3_v", 10);
        chk("t3_pc", if_pc, 32'h204);
        chk("t3_in", if_instr, 32'hC0DE_0200);

        freeze = 1'b1;
        a = if_pc;
        step(2);
        chk("t2_noreq0", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("t2_frz_pc", if_pc, a);
        step(1);
        chk("t2_noreq1", {31'd0, imem_bus.imem_req}, 32'd0);
        freeze = 1'b0;
        step(1);
        chk("t2_skid_v", {31'd0, if_valid}, 32'd1);
        chk("t2_skid_pc", if_pc, 32'h208);
        chk("t2_skid_in", if_instr, 32'hC0DE_0204);
        chk("t2_resume", {31'd0, imem_bus.imem_req}, 32'd1);

        freeze = 1'b1;
        step(2);
        chk("t5_stall", {31'd0, imem_bus.imem_req}, 32'd0);
        branch_taken = 1'b1;
        branch_addr = 32'h300;
        step(1);
        branch_taken = 1'b0;
        chk("t5_bub", {31'd0, if_valid}, 32'd0);
        chk("t5_addr", imem_bus.imem_addr, 32'h300);
        wait_valid("t5_v", 10);
        chk("t5_pc", if_pc, 32'h304);
        chk("t5_in", if_instr, 32'hC0DE_0300);
        freeze = 1'b0;

        wait_req("t6_req", 10);
        imem_bus.imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t6_stable", imem_bus.imem_addr, 32'h304);
        end
        imem_bus.imem_ready = 1'b1;
        lat = 3;
        step(1);
        rst = 1'b1;
        step(1);
        chk("t6_rst_v", {31'd0, if_valid}, 32'd0);
        chk("t6_rst_pc", if_pc, 32'd0);
        chk("t6_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        rst = 1'b0;
        lat = 1;
        chk("t6_addr", imem_bus.imem_addr, 32'h100);

        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        step(1);
        branch_taken = 1'b0;
        wait_req("tw_req", 10);
        chk("tw_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        wait_valid("tw_v", 10);
        chk("tw_pc", if_pc, 32'h0);
        chk("tw_in", if_instr, 32'h3F21_FFFC);
        wait_req("tw_req2", 10);
        chk("tw_addr2", imem_bus.imem_addr, 32'h0);
        step(6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
